// File: rtl/note_player_if.sv
// Handshake between the song sequencer and the note player: the player requests
// load/next, the sequencer answers with the current note, its length and a run flag.
interface note_player_if;
  logic [3:0] note;
  logic [1:0] length;
  logic       run;
  logic       load;
  logic       next;

  modport master (output load, output next, input note, input length, input run);
  modport slave  (input load, input next, output note, output length, output run);
endinterface

// File: rtl/note_player.sv
// Note player: requests a song, then plays each note as a square wave (or rest)
// for its coded duration, inserts a silent gap and requests the next note.
module note_player #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned UNIT_CYCLES   = 6_250_000,
  parameter int unsigned GAP_CYCLES    = 500_000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          stop_i,
  note_player_if.master seq_if,
  output logic          speaker_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_PLAY   = 3'd3,
    S_GAP    = 3'd4,
    S_ADV    = 3'd5
  } state_e;

  // Half periods in clock cycles for C4..B4, resolved at elaboration.
  localparam logic [23:0] HP_C4 = 24'(CLK_HZ / (2 * 262));
  localparam logic [23:0] HP_D4 = 24'(CLK_HZ / (2 * 294));
  localparam logic [23:0] HP_E4 = 24'(CLK_HZ / (2 * 330));
  localparam logic [23:0] HP_F4 = 24'(CLK_HZ / (2 * 349));
  localparam logic [23:0] HP_G4 = 24'(CLK_HZ / (2 * 392));
  localparam logic [23:0] HP_A4 = 24'(CLK_HZ / (2 * 440));
  localparam logic [23:0] HP_B4 = 24'(CLK_HZ / (2 * 494));

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] UNIT_LEN    = 32'(UNIT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [23:0] hp_cnt_q, hp_cnt_d;
  logic [3:0]  note_q, note_d;
  logic [1:0]  len_q, len_d;
  logic        spk_q, spk_d;
  logic        load_q, load_d;
  logic        next_q, next_d;
  logic        busy_q, busy_d;

  logic [23:0] hp_last_s;
  logic        tone_s;
  logic [31:0] play_last_s;

  // Decode the latched note into tone/rest and its half-period terminal count.
  always_comb begin
    tone_s    = 1'b1;
    hp_last_s = 24'd0;
    case (note_q)
      4'd1:    hp_last_s = HP_C4 - 24'd1;
      4'd2:    hp_last_s = HP_D4 - 24'd1;
      4'd3:    hp_last_s = HP_E4 - 24'd1;
      4'd4:    hp_last_s = HP_F4 - 24'd1;
      4'd5:    hp_last_s = HP_G4 - 24'd1;
      4'd6:    hp_last_s = HP_A4 - 24'd1;
      4'd7:    hp_last_s = HP_B4 - 24'd1;
      default: tone_s    = 1'b0;
    endcase
  end

  // Duration codes 0..3 map to 1/2/4/8 units.
  assign play_last_s = (UNIT_LEN << len_q) - 32'd1;

  // Next-state logic; counters default to zero so every exit leaves them cleared.
  always_comb begin
    state_d  = state_q;
    cnt_d    = 32'd0;
    hp_cnt_d = 24'd0;
    note_d   = note_q;
    len_d    = len_q;
    spk_d    = 1'b0;
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            if (!seq_if.run) begin
              state_d = S_IDLE;
            end else begin
              note_d  = seq_if.note;
              len_d   = seq_if.length;
              state_d = S_PLAY;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_PLAY: begin
          if (!seq_if.run) begin
            state_d = S_IDLE;
          end else if (cnt_q == play_last_s) begin
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 32'd1;
            if (tone_s && (hp_cnt_q == hp_last_s)) begin
              spk_d = ~spk_q;
            end else begin
              hp_cnt_d = hp_cnt_q + 24'd1;
              spk_d    = spk_q;
            end
          end
        end
        S_GAP: begin
          if (!seq_if.run) begin
            state_d = S_IDLE;
          end else if (cnt_q == GAP_LAST) begin
            state_d = S_ADV;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_ADV: begin
          state_d = S_SETTLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so each pulse aligns with its state.
  assign load_d = (state_d == S_LOAD);
  assign next_d = (state_d == S_ADV);
  assign busy_d = (state_d != S_IDLE);

  // State, counters, latched note and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      hp_cnt_q <= 24'd0;
      note_q   <= 4'd0;
      len_q    <= 2'd0;
      spk_q    <= 1'b0;
      load_q   <= 1'b0;
      next_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_cnt_q <= hp_cnt_d;
      note_q   <= note_d;
      len_q    <= len_d;
      spk_q    <= spk_d;
      load_q   <= load_d;
      next_q   <= next_d;
      busy_q   <= busy_d;
    end
  end

  assign seq_if.load = load_q;
  assign seq_if.next = next_q;
  assign speaker_o   = spk_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: a small sequencer model feeds a song; the expected output
// timeline of every note is derived from note frequency, duration code and gap length.
module tb_note_player;

  localparam int CLK_HZ = 880_000;
  localparam int UNIT   = 2_000;
  localparam int GAP    = 100;
  localparam int SETTLE = 2;

  logic clk;
  logic rst_n;
  logic start_i;
  logic stop_i;
  logic speaker_o;
  logic busy_o;

  note_player_if sif ();

  note_player #(
    .CLK_HZ       (CLK_HZ),
    .UNIT_CYCLES  (UNIT),
    .GAP_CYCLES   (GAP),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .seq_if   (sif),
    .speaker_o(speaker_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int freq_hz [8] = '{0, 262, 294, 330, 349, 392, 440, 494};
  int song_n  [4];
  int song_l  [4];
  int ptr     = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] outs();
    return {busy_o, sif.load, sif.next, speaker_o};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed {busy,load,next,spk}=%b expected %b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic seq_drive();
    sif.note   = 4'(song_n[ptr]);
    sif.length = 2'(song_l[ptr]);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("load_pulse", outs(), 4'b1100);
    ptr = 0;
    seq_drive();
  endtask

  // Expected behaviour of one note, starting just after a load/next pulse cycle.
  task automatic play_check(input int play_n, input int gap_n, input bit do_adv);
    int  n, hp, e0;
    bit  tone;
    logic exp_spk;
    n    = song_n[ptr];
    tone = (n >= 1) && (n <= 7);
    hp   = tone ? CLK_HZ / (2 * freq_hz[n]) : 1;
    for (int i = 0; i < SETTLE; i++) begin
      step();
      chk("settle", outs(), 4'b1000);
    end
    e0 = errors;
    for (int p = 0; p < play_n; p++) begin
      step();
      exp_spk = tone ? 1'((p / hp) % 2) : 1'b0;
      chk("play", outs(), {3'b100, exp_spk});
      if (p == 0) begin
        sif.note   = 4'($urandom_range(0, 15));
        sif.length = 2'($urandom_range(0, 3));
      end
      if (errors != e0) break;
    end
    for (int g = 0; g < gap_n; g++) begin
      step();
      chk("gap", outs(), 4'b1000);
      if (errors != e0) break;
    end
    if (do_adv) begin
      step();
      chk("next_pulse", outs(), 4'b1010);
      ptr = (ptr + 1) % 4;
      seq_drive();
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int e0;
    e0 = errors;
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, outs(), 4'b0000);
      if (errors != e0) break;
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    sif.run    = 1'b1;
    sif.note   = 4'd0;
    sif.length = 2'd0;

    song_n[0] = 6;                     song_l[0] = 0;
    song_n[1] = 0;                     song_l[1] = 3;
    song_n[2] = $urandom_range(1, 7);  song_l[2] = $urandom_range(0, 2);
    song_n[3] = $urandom_range(0, 15); song_l[3] = $urandom_range(0, 2);

    step();
    step();
    chk("reset_state", outs(), 4'b0000);
    #3 rst_n = 1'b1;
    idle_check("idle_after_reset", 3);

    // Whole song, then back to the first note after wrap.
    do_start();
    for (int k = 0; k < 4; k++) begin
      play_check(UNIT << song_l[ptr], GAP, 1'b1);
    end

    // Reset while the A4 tone is high.
    play_check(1500, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_async", outs(), 4'b0000);
    #3 rst_n = 1'b1;
    idle_check("idle_after_midplay_reset", 5);

    // stop beats start in IDLE.
    start_i = 1'b1;
    stop_i  = 1'b1;
    step();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("stop_beats_start", outs(), 4'b0000);
    idle_check("stay_idle", 5);

    // stop in the middle of PLAY.
    do_start();
    play_check(700, 0, 1'b0);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("stop_midplay", outs(), 4'b0000);
    idle_check("no_next_after_stop", 300);

    // run low at the end of SETTLE aborts before PLAY.
    sif.run = 1'b0;
    do_start();
    play_check(0, 0, 1'b0);
    step();
    chk("run_low_settle", outs(), 4'b0000);
    sif.run = 1'b1;
    idle_check("idle_after_settle_abort", 5);

    // run dropped during GAP, then restart.
    do_start();
    play_check(UNIT << song_l[ptr], 37, 1'b0);
    sif.run = 1'b0;
    step();
    chk("run_drop_gap", outs(), 4'b0000);
    idle_check("no_next_after_run_drop", 300);
    sif.run = 1'b1;
    do_start();
    play_check(UNIT << song_l[ptr], GAP, 1'b1);
    play_check(UNIT << song_l[ptr], GAP, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
